// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register writeback stage.
package reg_writeback_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 4;
  localparam int unsigned MODE_W    = 5;
  localparam int unsigned PC_IDX    = 15;

  localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
  localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
  localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
  localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

  // addr sits in the MSBs so the queue can expose it as a per-entry tag.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [MODE_W-1:0]    mode;
    logic                 set_flags;
    logic [3:0]           flags;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Generic in-order queue: circular storage, head/tail pointers, occupancy
// counter and per-entry valid bits with the top TAG_W bits exposed per slot.
module wb_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [WIDTH-1:0]                wdata_i,
  input  logic                            pop_i,
  input  logic                            flush_i,
  output logic [WIDTH-1:0]                rdata_o,
  output logic [DEPTH-1:0]                vld_o,
  output logic [DEPTH-1:0][TAG_W-1:0]     tag_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PtrW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic                        push_ok, pop_ok;

  assign push_ok = push_i && !flush_i;
  assign pop_ok  = pop_i && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
      vld_d   = '0;
    end else begin
      if (push_ok) begin
        tail_d        = tail_q + 1'b1;
        vld_d[tail_q] = 1'b1;
      end
      if (pop_ok) begin
        head_d        = head_q + 1'b1;
        vld_d[head_q] = 1'b0;
      end
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      mem_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      if (push_ok) begin
        mem_q[tail_q] <= wdata_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      tag_o[i] = mem_q[i][WIDTH-1 -: TAG_W];
    end
  end

  assign rdata_o = mem_q[head_q];
  assign vld_o   = vld_q;
  assign count_o = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage in front of the register bank: in-order result queue,
// pending-write hazard detection and PC write flagging.
// Optional CPSR flag path enabled by defining REG_WRITEBACK_CPSR_EN.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ADDR_W-1:0]      in_addr_i,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic [4:0]             in_mode_i,
  input  logic                   in_set_flags_i,
  input  logic [3:0]             in_flags_i,
  input  logic                   flush_i,
  input  logic                   bank_busy_i,
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [DATA_W-1:0]      wr_data_o,
  output logic [4:0]             wr_mode_o,
  output logic                   pc_wr_o,
  input  logic [ADDR_W-1:0]      rd_addr_a_i,
  input  logic [ADDR_W-1:0]      rd_addr_b_i,
  output logic                   hazard_a_o,
  output logic                   hazard_b_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef REG_WRITEBACK_CPSR_EN
  ,
  output logic                   cpsr_wr_en_o,
  output logic [3:0]             cpsr_flags_o
`endif
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = $bits(wb_entry_t);
`ifdef REG_WRITEBACK_CPSR_EN
  localparam int unsigned QueueW = EntryW;
`else
  // Flag fields are not stored when the CPSR path is compiled out.
  localparam int unsigned QueueW = EntryW - 5;
`endif

  wb_entry_t                        push_entry, head_entry;
  logic [QueueW-1:0]                q_wdata, q_rdata;
  logic [CntW-1:0]                  count;
  logic [DEPTH-1:0]                 vld;
  logic [DEPTH-1:0][WB_ADDR_W-1:0]  tags;
  logic                             push;

  assign in_ready_o = (count < CntW'(DEPTH)) && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign wr_en_o    = (count != '0) && !bank_busy_i && !flush_i;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = WB_ADDR_W'(in_addr_i);
    push_entry.data = WB_DATA_W'(in_data_i);
    push_entry.mode = in_mode_i;
`ifdef REG_WRITEBACK_CPSR_EN
    push_entry.set_flags = in_set_flags_i;
    push_entry.flags     = in_flags_i;
`endif
  end

`ifdef REG_WRITEBACK_CPSR_EN
  assign q_wdata      = push_entry;
  assign head_entry   = q_rdata;
  assign cpsr_wr_en_o = wr_en_o && head_entry.set_flags;
  assign cpsr_flags_o = head_entry.flags;
`else
  assign q_wdata    = push_entry[EntryW-1:5];
  assign head_entry = {q_rdata, 5'b0};
  logic unused_flags;
  assign unused_flags = ^{in_set_flags_i, in_flags_i, push_entry.set_flags, push_entry.flags,
                          head_entry.set_flags, head_entry.flags};
`endif

  wb_queue #(
    .WIDTH (QueueW),
    .TAG_W (WB_ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (q_wdata),
    .pop_i   (wr_en_o),
    .flush_i (flush_i),
    .rdata_o (q_rdata),
    .vld_o   (vld),
    .tag_o   (tags),
    .count_o (count)
  );

  assign wr_addr_o = ADDR_W'(head_entry.addr);
  assign wr_data_o = DATA_W'(head_entry.data);
  assign wr_mode_o = head_entry.mode;
  assign pc_wr_o   = wr_en_o && (wr_addr_o == ADDR_W'(PC_IDX));
  assign count_o   = count;

  // Mode is deliberately ignored: any queued write to the index stalls the read.
  always_comb begin
    hazard_a_o = 1'b0;
    hazard_b_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld[i] && (tags[i] == WB_ADDR_W'(rd_addr_a_i))) hazard_a_o = 1'b1;
      if (vld[i] && (tags[i] == WB_ADDR_W'(rd_addr_b_i))) hazard_b_o = 1'b1;
    end
  end

endmodule
